// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   state_e        : loader FSM states
//   HeaderBytes    : length of the word-count header in the stream
//   is_receiving() : states in which the loader accepts stream bytes
package instruction_loader_pkg;

  typedef enum logic [2:0] {
    StHdrHi = 3'd0,
    StHdrLo = 3'd1,
    StData  = 3'd2,
    StWrite = 3'd3,
    StChk   = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

  localparam int unsigned HeaderBytes = 2;

  function automatic logic is_receiving(state_e s);
    return (s == StHdrHi) || (s == StHdrLo) || (s == StData) || (s == StChk);
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write bus of the loader.
//   InData/InValid/InReady          : byte stream with valid/ready handshake
//   IMemWrite/IMemAddr/IMemWriteData: one-cycle word write strobe, address, data
// The slave modport is the loader side; master is the source/memory side.
interface instruction_loader_if;

  logic [7:0]  InData;
  logic        InValid;
  logic        InReady;
  logic        IMemWrite;
  logic [31:0] IMemAddr;
  logic [31:0] IMemWriteData;

  modport master (
    output InData, InValid,
    input  InReady, IMemWrite, IMemAddr, IMemWriteData
  );

  modport slave (
    input  InData, InValid,
    output InReady, IMemWrite, IMemAddr, IMemWriteData
  );

endinterface

// File: rtl/loader_word_assembler.sv
// Collects four stream bytes into a big-endian 32-bit word.
//   clk_i        : clock
//   rst_ni       : synchronous active-low reset
//   byte_valid_i : shift byte_i in this cycle
//   byte_i       : stream byte
//   word_o       : shift register; first byte of a word lands in [31:24]
//   word_done_o  : combinational, high when the 4th byte of a word is shifted in
module loader_word_assembler (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (byte_valid_i) begin
      shift_d = {shift_q[23:0], byte_i};
      idx_d   = idx_q + 2'd1;  // wraps 3 -> 0 at word completion
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q <= 32'd0;
      idx_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign word_o      = shift_q;
  assign word_done_o = byte_valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Boot-time instruction memory writer.
// Receives: count hi, count lo, 4*count data bytes (MSB first), checksum byte.
// Each assembled word is written at BASE_ADDR + 4*n. The core is held in reset
// until the checksum (8-bit sum of all preceding bytes) matches.
//   Clk       : clock
//   Reset     : synchronous active-low reset
//   bus       : stream input and instruction-memory write port (slave side)
//   CoreReset : active-high core reset, released only after a verified load
//   Done      : sticky, image loaded and verified
//   Error     : sticky, image rejected (oversize count or bad checksum)
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                       Clk,
  input  logic                       Reset,
  instruction_loader_if.slave        bus,
  output logic                       CoreReset,
  output logic                       Done,
  output logic                       Error
);

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] count_q, count_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  sum_q, sum_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        core_rst_q, core_rst_d;

  logic        accept;
  logic        asm_valid;
  logic        word_done;
  logic [31:0] word;
  logic [15:0] hdr_count;

  assign accept    = bus.InValid && ready_q;
  assign asm_valid = accept && (state_q == StData);

  loader_word_assembler u_word_assembler (
    .clk_i        (Clk),
    .rst_ni       (Reset),
    .byte_valid_i (asm_valid),
    .byte_i       (bus.InData),
    .word_o       (word),
    .word_done_o  (word_done)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    wcnt_d     = wcnt_q;
    sum_d      = sum_q;
    done_d     = done_q;
    err_d      = err_q;
    core_rst_d = core_rst_q;
    hdr_count  = {count_q[15:8], bus.InData};

    unique case (state_q)
      StHdrHi: begin
        if (accept) begin
          count_d[15:8] = bus.InData;
          sum_d         = sum_q + bus.InData;
          state_d       = StHdrLo;
        end
      end
      StHdrLo: begin
        if (accept) begin
          count_d[7:0] = bus.InData;
          sum_d        = sum_q + bus.InData;
          if ({16'd0, hdr_count} > DEPTH_WORDS) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else if (hdr_count == 16'd0) begin
            state_d = StChk;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          sum_d = sum_q + bus.InData;
          if (word_done) state_d = StWrite;
        end
      end
      StWrite: begin
        // Strobe is high this cycle with the current address; advance after it.
        addr_d  = addr_q + 32'd4;
        wcnt_d  = wcnt_q + 16'd1;
        state_d = (wcnt_q + 16'd1 == count_q) ? StChk : StData;
      end
      StChk: begin
        if (accept) begin
          if (bus.InData == sum_q) begin
            state_d    = StDone;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
      StDone, StErr: begin
        // Terminal until reset.
      end
      default: begin
        state_d = StErr;
        err_d   = 1'b1;
      end
    endcase

    // Registered decodes of the next state so they align with state_q.
    ready_d = is_receiving(state_d);
    write_d = (state_d == StWrite);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= StHdrHi;
      ready_q    <= 1'b1;
      write_q    <= 1'b0;
      addr_q     <= BASE_ADDR;
      count_q    <= 16'd0;
      wcnt_q     <= 16'd0;
      sum_q      <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wcnt_q     <= wcnt_d;
      sum_q      <= sum_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign bus.InReady       = ready_q;
  assign bus.IMemWrite     = write_q;
  assign bus.IMemAddr      = addr_q;
  assign bus.IMemWriteData = word;
  assign CoreReset         = core_rst_q;
  assign Done              = done_q;
  assign Error             = err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: per-byte vector tables with expected
// strobe/address/data/status after each handshake, plus multi-cycle sequences.
module tb_instruction_loader;

  localparam logic [31:0] Base = 32'h0000_1000;

  logic Clk = 1'b0;
  logic Reset;
  logic CoreReset, Done, Error;

  instruction_loader_if bus ();

  instruction_loader #(
    .DEPTH_WORDS (128),
    .BASE_ADDR   (Base)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .bus       (bus),
    .CoreReset (CoreReset),
    .Done      (Done),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  data;
    bit          exp_wr;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   wr_count = 0;
  int   w0;

  always @(negedge Clk) begin
    if (Reset === 1'b1 && bus.IMemWrite === 1'b1) wr_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input bit wr, input logic [31:0] a,
                     input logic [31:0] w, input bit dn, input bit er);
    vec_t v;
    v.data = d; v.exp_wr = wr; v.exp_addr = a; v.exp_wdata = w;
    v.exp_done = dn; v.exp_err = er;
    tbl.push_back(v);
  endtask

  task automatic load_nominal(input logic [7:0] chk, input bit dn, input bit er);
    tbl.delete();
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h02, 0, 0, 0, 0, 0);
    add(8'h20, 0, 0, 0, 0, 0);
    add(8'h08, 0, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h05, 1, Base, 32'h2008_0005, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h00, 1, Base + 32'd4, 32'h0000_0000, 0, 0);
    add(chk, 0, 0, 0, dn, er);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] b, output bit ok);
    int n = 0;
    bus.InData  = b;
    bus.InValid = 1'b1;
    while (bus.InReady !== 1'b1 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    ok = (bus.InReady === 1'b1);
    @(negedge Clk);
    bus.InValid = 1'b0;
  endtask

  task automatic run_table(input string tag, input int gap);
    bit ok;
    foreach (tbl[i]) begin
      repeat (gap) @(negedge Clk);
      send(tbl[i].data, ok);
      check($sformatf("%s[%0d] handshake", tag, i), {31'd0, ok}, 32'd1);
      check($sformatf("%s[%0d] IMemWrite", tag, i), {31'd0, bus.IMemWrite},
            {31'd0, tbl[i].exp_wr});
      if (tbl[i].exp_wr) begin
        check($sformatf("%s[%0d] IMemAddr", tag, i), bus.IMemAddr, tbl[i].exp_addr);
        check($sformatf("%s[%0d] IMemWriteData", tag, i), bus.IMemWriteData, tbl[i].exp_wdata);
      end
      check($sformatf("%s[%0d] InReady", tag, i), {31'd0, bus.InReady},
            {31'd0, !(tbl[i].exp_wr || tbl[i].exp_done || tbl[i].exp_err)});
      check($sformatf("%s[%0d] Done", tag, i), {31'd0, Done}, {31'd0, tbl[i].exp_done});
      check($sformatf("%s[%0d] Error", tag, i), {31'd0, Error}, {31'd0, tbl[i].exp_err});
      check($sformatf("%s[%0d] CoreReset", tag, i), {31'd0, CoreReset},
            {31'd0, !tbl[i].exp_done});
    end
  endtask

  task automatic do_reset();
    Reset       = 1'b0;
    bus.InValid = 1'b0;
    bus.InData  = 8'h00;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " InReady"}, {31'd0, bus.InReady}, 32'd1);
    check({tag, " IMemWrite"}, {31'd0, bus.IMemWrite}, 32'd0);
    check({tag, " IMemAddr"}, bus.IMemAddr, Base);
    check({tag, " IMemWriteData"}, bus.IMemWriteData, 32'd0);
    check({tag, " CoreReset"}, {31'd0, CoreReset}, 32'd1);
    check({tag, " Done"}, {31'd0, Done}, 32'd0);
    check({tag, " Error"}, {31'd0, Error}, 32'd0);
  endtask

  // Offer junk bytes while the loader should be refusing them.
  task automatic hold_junk(input int cycles);
    bus.InData  = 8'hFF;
    bus.InValid = 1'b1;
    repeat (cycles) @(negedge Clk);
    bus.InValid = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    bit ok;
    Reset       = 1'b0;
    bus.InValid = 1'b0;
    bus.InData  = 8'h00;
    @(negedge Clk);

    // Nominal load
    do_reset();
    check_reset("reset");
    w0 = wr_count;
    load_nominal(8'h2F, 1, 0);
    run_table("nominal", 0);
    hold_junk(4);
    check("nominal sticky InReady", {31'd0, bus.InReady}, 32'd0);
    check("nominal sticky Done", {31'd0, Done}, 32'd1);
    check("nominal sticky CoreReset", {31'd0, CoreReset}, 32'd0);
    check("nominal write count", wr_count - w0, 32'd2);

    // Empty image
    do_reset();
    w0 = wr_count;
    tbl.delete();
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h00, 0, 0, 0, 1, 0);
    run_table("empty", 0);
    repeat (3) @(negedge Clk);
    check("empty write count", wr_count - w0, 32'd0);
    check("empty Done", {31'd0, Done}, 32'd1);

    // Bad checksum
    do_reset();
    w0 = wr_count;
    load_nominal(8'h30, 0, 1);
    run_table("badchk", 0);
    hold_junk(4);
    check("badchk InReady", {31'd0, bus.InReady}, 32'd0);
    check("badchk Error", {31'd0, Error}, 32'd1);
    check("badchk Done", {31'd0, Done}, 32'd0);
    check("badchk CoreReset", {31'd0, CoreReset}, 32'd1);
    check("badchk write count", wr_count - w0, 32'd2);

    // Oversize header (129 words)
    do_reset();
    w0 = wr_count;
    tbl.delete();
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h81, 0, 0, 0, 0, 1);
    run_table("oversize", 0);
    hold_junk(5);
    check("oversize InReady", {31'd0, bus.InReady}, 32'd0);
    check("oversize Error", {31'd0, Error}, 32'd1);
    check("oversize write count", wr_count - w0, 32'd0);

    // Exactly DEPTH_WORDS is accepted
    do_reset();
    tbl.delete();
    add(8'h00, 0, 0, 0, 0, 0);
    add(8'h80, 0, 0, 0, 0, 0);
    run_table("maxcount", 0);

    // Stalled source
    do_reset();
    w0 = wr_count;
    load_nominal(8'h2F, 1, 0);
    run_table("stalled", 3);
    repeat (3) @(negedge Clk);
    check("stalled write count", wr_count - w0, 32'd2);

    // Mid-load reset after the 5th byte
    do_reset();
    load_nominal(8'h2F, 1, 0);
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].data, ok);
      check($sformatf("midrst pre[%0d] handshake", i), {31'd0, ok}, 32'd1);
    end
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    check_reset("midrst");
    w0 = wr_count;
    run_table("midrst", 0);
    repeat (3) @(negedge Clk);
    check("midrst write count", wr_count - w0, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
